// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: sequencer state encoding, the bundle
// of pipeline control outputs, and canned control patterns used by the sequencer.
package hazard_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        RAW_STALL = 3'd1,
        MEM_WAIT  = 3'd2,
        DRAIN     = 3'd3,
        HALTED    = 3'd4
    } hazard_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_hold;
        logic halted;
    } hazard_ctrl_t;

    function automatic hazard_ctrl_t ctrl_run();
        return '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
    endfunction

    // Hold PC and IF/ID, push a NOP into ID/EX.
    function automatic hazard_ctrl_t ctrl_bubble();
        return '{id_ex_bubble: 1'b1, default: 1'b0};
    endfunction

    function automatic hazard_ctrl_t ctrl_freeze();
        return '{pipe_hold: 1'b1, default: 1'b0};
    endfunction

    function automatic hazard_ctrl_t ctrl_flush();
        return '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                 id_ex_flush: 1'b1, default: 1'b0};
    endfunction

    function automatic hazard_ctrl_t ctrl_halted();
        return '{pipe_hold: 1'b1, halted: 1'b1, default: 1'b0};
    endfunction

endpackage

// File: rtl/hazard_raw_detect.sv
// Distance-1 RAW compare: producer in EX, consumer in ID. x0 never creates a hazard.
module hazard_raw_detect
    import hazard_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs2,
    input  logic [4:0] rd,
    input  logic       regwrite,
    output logic       raw
);

    assign raw = regwrite && (rd != REG_ZERO) &&
                 ((rd == rs1) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage RV32 core: RAW bubbles, memory freeze, branch
// flush and halt drain. Optional HAZARD_STATS_EN adds free-running event counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int RAW_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    if_id_rs1,
    input  logic [4:0]    if_id_rs2,
    input  logic          if_id_uses_rs2,
    input  logic [4:0]    id_ex_rd,
    input  logic          id_ex_regwrite,
    input  logic          branch_taken,
    input  logic          mem_busy,
    input  logic          halt_req,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          id_ex_bubble,
    output logic          if_id_flush,
    output logic          id_ex_flush,
    output logic          pipe_hold,
    output logic          halted,
    output hazard_state_e fsm_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_count,
    output logic [31:0]   freeze_cycles
`endif
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    hazard_state_e      state, state_next;
    hazard_state_e      resume_state, resume_next;
    hazard_state_e      eff_state;
    logic [1:0]         stall_cnt, stall_next;
    logic [DRAIN_W-1:0] drain_cnt, drain_next;
    logic               pend_flush, pend_next;
    logic               raw;
    logic               drain_final;
    hazard_ctrl_t       ctrl;

    hazard_raw_detect u_raw (
        .rs1      (if_id_rs1),
        .rs2      (if_id_rs2),
        .uses_rs2 (if_id_uses_rs2),
        .rd       (id_ex_rd),
        .regwrite (id_ex_regwrite),
        .raw      (raw)
    );

    // MEM_WAIT only marks a freeze; once memory is ready the frozen state resumes
    // in the same cycle, so all decisions are taken on the effective state.
    assign eff_state   = (state == MEM_WAIT) ? resume_state : state;
    assign drain_final = (eff_state == DRAIN) && (drain_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            resume_state <= RUN;
            stall_cnt    <= '0;
            drain_cnt    <= '0;
            pend_flush   <= 1'b0;
        end else begin
            state        <= state_next;
            resume_state <= resume_next;
            stall_cnt    <= stall_next;
            drain_cnt    <= drain_next;
            pend_flush   <= pend_next;
        end
    end

    always_comb begin
        ctrl        = ctrl_run();
        state_next  = state;
        resume_next = resume_state;
        stall_next  = stall_cnt;
        drain_next  = drain_cnt;
        pend_next   = pend_flush;

        if (eff_state == HALTED || drain_final) begin
            ctrl       = ctrl_halted();
            state_next = HALTED;
        end else if (mem_busy) begin
            ctrl = ctrl_freeze();
            if (state != MEM_WAIT) begin
                state_next  = MEM_WAIT;
                resume_next = state;
            end
            if (branch_taken) begin
                pend_next = 1'b1;
            end
        end else if (eff_state == DRAIN) begin
            // Instructions past the halting one are already bubbles; nothing to flush.
            ctrl       = ctrl_bubble();
            drain_next = drain_cnt - DRAIN_W'(1);
            state_next = DRAIN;
        end else if (branch_taken || pend_flush) begin
            ctrl       = ctrl_flush();
            pend_next  = 1'b0;
            stall_next = '0;
            state_next = RUN;
        end else if (halt_req) begin
            if (eff_state == RAW_STALL || raw) begin
                ctrl = ctrl_bubble();
            end
            stall_next = '0;
            drain_next = DRAIN_W'(DRAIN_CYCLES);
            state_next = DRAIN;
        end else if (eff_state == RAW_STALL) begin
            ctrl       = ctrl_bubble();
            stall_next = stall_cnt - 2'd1;
            state_next = (stall_cnt <= 2'd1) ? RUN : RAW_STALL;
        end else if (raw) begin
            ctrl = ctrl_bubble();
            if (RAW_STALL_CYCLES > 1) begin
                state_next = RAW_STALL;
                stall_next = 2'(RAW_STALL_CYCLES - 1);
            end else begin
                state_next = RUN;
            end
        end else begin
            state_next = RUN;
        end

        if (rst) begin
            ctrl = ctrl_bubble();
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign pipe_hold    = ctrl.pipe_hold;
    assign halted       = ctrl.halted;
    assign fsm_state    = state;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            flush_count   <= '0;
            freeze_cycles <= '0;
        end else begin
            if (id_ex_bubble) stall_cycles  <= stall_cycles + 32'd1;
            if (if_id_flush)  flush_count   <= flush_count + 32'd1;
            if (pipe_hold)    freeze_cycles <= freeze_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit: one instance with single-cycle RAW
// stalls, one with three-cycle stalls; a per-instance expected queue feeds a monitor.
module tb_hazard_control_unit;
    import hazard_pkg::*;

    // Output vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush,
    //                       id_ex_flush, pipe_hold, halted}
    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_BUB   = 7'b0010000;
    localparam logic [6:0] O_RST   = 7'b0010000;
    localparam logic [6:0] O_FLUSH = 7'b1101100;
    localparam logic [6:0] O_HOLD  = 7'b0000010;
    localparam logic [6:0] O_HALT  = 7'b0000011;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic [4:0] if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rd = '0;
    logic if_id_uses_rs2 = 1'b0, id_ex_regwrite = 1'b0;
    logic branch_taken = 1'b0, mem_busy = 1'b0, halt_req = 1'b0;

    logic [6:0] out_a, out_b;
    hazard_state_e fsm_state_a, fsm_state_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_a, flush_a, freeze_a, stall_b, flush_b, freeze_b;
`endif

    logic [6:0] exp_a_q[$], exp_b_q[$];
    string      nm_a_q[$],  nm_b_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.RAW_STALL_CYCLES(1), .DRAIN_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst_a),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_write(out_a[6]), .if_id_write(out_a[5]), .id_ex_bubble(out_a[4]),
        .if_id_flush(out_a[3]), .id_ex_flush(out_a[2]), .pipe_hold(out_a[1]),
        .halted(out_a[0]), .fsm_state(fsm_state_a)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_a), .flush_count(flush_a), .freeze_cycles(freeze_a)
`endif
    );

    hazard_control_unit #(.RAW_STALL_CYCLES(3), .DRAIN_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst_b),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_write(out_b[6]), .if_id_write(out_b[5]), .id_ex_bubble(out_b[4]),
        .if_id_flush(out_b[3]), .id_ex_flush(out_b[2]), .pipe_hold(out_b[1]),
        .halted(out_b[0]), .fsm_state(fsm_state_b)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_b), .flush_count(flush_b), .freeze_cycles(freeze_b)
`endif
    );

    // Drive one cycle of inputs to the selected instance (the other is held in reset)
    // and queue the outputs expected during that cycle.
    task automatic step(input bit sel_b, input string nm, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw,
                        input logic bt, input logic mb, input logic hr,
                        input logic [6:0] exp);
        @(posedge clk);
        #1;
        if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_uses_rs2 = u2;
        id_ex_rd = rd; id_ex_regwrite = rw;
        branch_taken = bt; mem_busy = mb; halt_req = hr;
        if (sel_b) begin
            rst_a = 1'b1; rst_b = r;
            exp_b_q.push_back(exp); nm_b_q.push_back(nm);
        end else begin
            rst_b = 1'b1; rst_a = r;
            exp_a_q.push_back(exp); nm_a_q.push_back(nm);
        end
    endtask

    task automatic idle(input bit sel_b, input string nm, input logic bt, input logic mb,
                        input logic hr, input logic [6:0] exp);
        step(sel_b, nm, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, bt, mb, hr, exp);
    endtask

    // add x5,... in EX followed by add x6,x5,x1 in ID
    task automatic raw_v(input bit sel_b, input string nm, input logic bt, input logic mb,
                         input logic [6:0] exp);
        step(sel_b, nm, 1'b0, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, bt, mb, 1'b0, exp);
    endtask

    task automatic rst_v(input bit sel_b, input string nm);
        step(sel_b, nm, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST);
    endtask

    // Monitor: every cycle, compare each instance against its next queued expectation.
    always @(negedge clk) begin
        if (exp_a_q.size() > 0) begin
            logic [6:0] e;
            string n;
            e = exp_a_q.pop_front();
            n = nm_a_q.pop_front();
            n_checks++;
            if (out_a !== e) begin
                n_fail++;
                $display("FAIL a:%s got=%b exp=%b (pc,ifid,bub,fl1,fl2,hold,halt)", n, out_a, e);
            end
        end
        if (exp_b_q.size() > 0) begin
            logic [6:0] e;
            string n;
            e = exp_b_q.pop_front();
            n = nm_b_q.pop_front();
            n_checks++;
            if (out_b !== e) begin
                n_fail++;
                $display("FAIL b:%s got=%b exp=%b (pc,ifid,bub,fl1,fl2,hold,halt)", n, out_b, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- instance a: RAW_STALL_CYCLES=1 ----
        rst_v(0, "reset0");
        rst_v(0, "reset1");
        idle(0, "run_idle", 0, 0, 0, O_RUN);
        raw_v(0, "raw_rs1", 0, 0, O_BUB);
        idle(0, "raw_release", 0, 0, 0, O_RUN);
        step(0, "rd_x0", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 0, 0, 0, O_RUN);
        step(0, "rs2_unused", 1'b0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 0, 0, 0, O_RUN);
        step(0, "rs2_used", 1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 0, 0, 0, O_BUB);
        step(0, "no_regwrite", 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 0, 0, 0, O_RUN);
        raw_v(0, "flush_over_raw", 1, 0, O_FLUSH);
        idle(0, "after_flush", 0, 0, 0, O_RUN);
        idle(0, "busy_c1", 0, 1, 0, O_HOLD);
        idle(0, "busy_c2_br", 1, 1, 0, O_HOLD);
        idle(0, "busy_c3", 0, 1, 0, O_HOLD);
        idle(0, "busy_c4", 0, 1, 0, O_HOLD);
        idle(0, "pend_flush_c5", 0, 0, 0, O_FLUSH);
        idle(0, "after_pend", 0, 0, 0, O_RUN);
        raw_v(0, "busy_over_raw", 0, 1, O_HOLD);
        raw_v(0, "raw_after_busy", 0, 0, O_BUB);
        idle(0, "raw_done", 0, 0, 0, O_RUN);
        idle(0, "flush_with_halt", 1, 0, 1, O_FLUSH);
        idle(0, "halt_squashed", 0, 0, 0, O_RUN);
        idle(0, "halt_req", 0, 0, 1, O_RUN);
        idle(0, "drain1", 0, 0, 0, O_BUB);
        idle(0, "drain2", 0, 0, 0, O_BUB);
        idle(0, "drain3", 0, 0, 0, O_BUB);
        idle(0, "halted", 0, 0, 0, O_HALT);
        idle(0, "halted_sticky", 0, 0, 0, O_HALT);
        idle(0, "halted_busy", 0, 1, 0, O_HALT);
        idle(0, "halted_branch", 1, 0, 0, O_HALT);
        rst_v(0, "reset_from_halt");
        idle(0, "run_after_halt", 0, 0, 0, O_RUN);
        idle(0, "halt_req2", 0, 0, 1, O_RUN);
        idle(0, "drain_a", 0, 0, 0, O_BUB);
        idle(0, "drain_busy", 0, 1, 0, O_HOLD);
        idle(0, "drain_b", 0, 0, 0, O_BUB);
        idle(0, "drain_c", 0, 0, 0, O_BUB);
        idle(0, "halted2", 0, 0, 0, O_HALT);
        rst_v(0, "reset_a_end");
        idle(0, "run_a_end", 0, 0, 0, O_RUN);

        // ---- instance b: RAW_STALL_CYCLES=3 ----
        rst_v(1, "reset_b");
        idle(1, "run_b", 0, 0, 0, O_RUN);
        raw_v(1, "raw3_c1", 0, 0, O_BUB);
        idle(1, "raw3_c2", 0, 0, 0, O_BUB);
        idle(1, "raw3_c3", 0, 0, 0, O_BUB);
        idle(1, "raw3_resume", 0, 0, 0, O_RUN);
        raw_v(1, "stall_br_c1", 0, 0, O_BUB);
        idle(1, "stall_br_c2", 0, 0, 0, O_BUB);
        idle(1, "branch_in_stall", 1, 0, 0, O_FLUSH);
        idle(1, "stall_aborted", 0, 0, 0, O_RUN);
        raw_v(1, "stall_busy_c1", 0, 0, O_BUB);
        idle(1, "stall_frozen", 0, 1, 0, O_HOLD);
        idle(1, "stall_busy_c2", 0, 0, 0, O_BUB);
        idle(1, "stall_busy_c3", 0, 0, 0, O_BUB);
        idle(1, "stall_busy_done", 0, 0, 0, O_RUN);
        raw_v(1, "rst_mid_c1", 0, 0, O_BUB);
        idle(1, "rst_mid_c2", 0, 0, 0, O_BUB);
        rst_v(1, "rst_mid_stall");
        idle(1, "no_residue1", 0, 0, 0, O_RUN);
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        #1;
        n_checks++;
        if ({stall_b, flush_b, freeze_b} !== 96'd0) begin
            n_fail++;
            $display("FAIL stats_after_rst: got stall=%0d flush=%0d freeze=%0d exp all 0",
                     stall_b, flush_b, freeze_b);
        end
`endif
        idle(1, "no_residue2", 0, 0, 0, O_RUN);

        for (int i = 0; i < 20 && (exp_a_q.size() + exp_b_q.size()) > 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if ((exp_a_q.size() + exp_b_q.size()) != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending exp 0", exp_a_q.size() + exp_b_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
